// File: rtl/vga_pkg.sv
// Shared display/input definitions: key codes, PS/2 set-2 scancodes, decoder states.
package vga_pkg;

    localparam int unsigned KEY_W   = 4;
    localparam int unsigned BYTE_W  = 8;
    localparam int unsigned FRAME_W = 11;

    typedef enum logic [KEY_W-1:0] {
        key_relesed = 4'd0,
        key_A       = 4'd1,
        key_S       = 4'd2,
        key_W       = 4'd3,
        key_D       = 4'd4,
        key_1       = 4'd5,
        key_2       = 4'd6,
        key_3       = 4'd7,
        key_4       = 4'd8,
        key_esc     = 4'd9
    } key_t;

    localparam logic [BYTE_W-1:0] SC_BREAK = 8'hF0;
    localparam logic [BYTE_W-1:0] SC_EXT   = 8'hE0;
    localparam logic [BYTE_W-1:0] SC_A     = 8'h1C;
    localparam logic [BYTE_W-1:0] SC_S     = 8'h1B;
    localparam logic [BYTE_W-1:0] SC_W     = 8'h1D;
    localparam logic [BYTE_W-1:0] SC_D     = 8'h23;
    localparam logic [BYTE_W-1:0] SC_1     = 8'h16;
    localparam logic [BYTE_W-1:0] SC_2     = 8'h1E;
    localparam logic [BYTE_W-1:0] SC_3     = 8'h26;
    localparam logic [BYTE_W-1:0] SC_4     = 8'h25;
    localparam logic [BYTE_W-1:0] SC_ESC   = 8'h76;

    typedef enum logic [1:0] {
        DEC_IDLE      = 2'd0,
        DEC_BREAK     = 2'd1,
        DEC_EXT       = 2'd2,
        DEC_EXT_BREAK = 2'd3
    } dec_state_t;

    // Make code to key code; key_relesed means "not a mapped key".
    function automatic key_t sc_to_key(input logic [BYTE_W-1:0] sc);
        key_t k;
        k = key_relesed;
        case (sc)
            SC_A:    k = key_A;
            SC_S:    k = key_S;
            SC_W:    k = key_W;
            SC_D:    k = key_D;
            SC_1:    k = key_1;
            SC_2:    k = key_2;
            SC_3:    k = key_3;
            SC_4:    k = key_4;
            SC_ESC:  k = key_esc;
            default: k = key_relesed;
        endcase
        return k;
    endfunction

endpackage

// File: rtl/keyboard_ctl_ps2_rx.sv
// PS/2 frame receiver: synchronizes the raw lines, assembles 11-bit frames,
// abandons stalled frames after TIMEOUT_CYCLES idle cycles.
// Frame checking (start/parity/stop) only with KEYBOARD_PARITY_CHECK_EN defined.
module ps2_rx
    import vga_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 65000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ps2_clk_i,
    input  logic              ps2_data_i,
    output logic [BYTE_W-1:0] byte_o,
    output logic              byte_valid_o,
    output logic              frame_err_o
);

    localparam int unsigned CNT_W   = 4;
    localparam int unsigned SHIFT_W = BYTE_W + 1;
    localparam int unsigned TMO_W   = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(FRAME_W - 1);

    logic [1:0]         clk_sync_q;
    logic [1:0]         data_sync_q;
    logic               clk_prev_q;
    logic               ps2_clk_s;
    logic               ps2_data_s;
    logic               fall_c;
    logic               last_fall_c;
    logic               frame_ok_c;

    logic [CNT_W-1:0]   bit_cnt_q,    bit_cnt_d;
    logic [SHIFT_W-1:0] shift_q,      shift_d;
    logic [TMO_W-1:0]   tmo_q,        tmo_d;
    logic [BYTE_W-1:0]  byte_q,       byte_d;
    logic               byte_valid_q, byte_valid_d;

    assign ps2_clk_s   = clk_sync_q[1];
    assign ps2_data_s  = data_sync_q[1];
    assign fall_c      = clk_prev_q & ~ps2_clk_s;
    assign last_fall_c = fall_c & (bit_cnt_q == LAST_BIT);

    // Two-flop synchronizers plus previous-clock flop for edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clk_sync_q  <= 2'b11;
            data_sync_q <= 2'b11;
            clk_prev_q  <= 1'b1;
        end else begin
            clk_sync_q  <= {clk_sync_q[0], ps2_clk_i};
            data_sync_q <= {data_sync_q[0], ps2_data_i};
            clk_prev_q  <= ps2_clk_s;
        end
    end

`ifdef KEYBOARD_PARITY_CHECK_EN
    logic start_q;
    logic err_q;
    logic err_d;

    // shift_q holds data+parity once the stop bit arrives; odd parity => XOR is 1.
    assign frame_ok_c = ~start_q & (^shift_q) & ps2_data_s;
    assign err_d      = last_fall_c & ~frame_ok_c;
    assign frame_err_o = err_q;

    // Capture the start bit and register the reject pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            start_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            if (fall_c && (bit_cnt_q == '0)) begin
                start_q <= ps2_data_s;
            end
            err_q <= err_d;
        end
    end
`else
    assign frame_ok_c  = 1'b1;
    assign frame_err_o = 1'b0;
`endif

    // Bit counting, shifting, idle timeout and byte hand-off.
    always_comb begin
        bit_cnt_d    = bit_cnt_q;
        shift_d      = shift_q;
        tmo_d        = tmo_q;
        byte_d       = byte_q;
        byte_valid_d = 1'b0;
        if (fall_c) begin
            // Any edge restarts the idle window, so a frame end beats a timeout.
            tmo_d = '0;
            if (last_fall_c) begin
                bit_cnt_d = '0;
                if (frame_ok_c) begin
                    byte_d       = shift_q[BYTE_W-1:0];
                    byte_valid_d = 1'b1;
                end
            end else begin
                shift_d   = {ps2_data_s, shift_q[SHIFT_W-1:1]};
                bit_cnt_d = bit_cnt_q + CNT_W'(1);
            end
        end else if (bit_cnt_q != '0) begin
            if (tmo_q == TMO_LAST) begin
                bit_cnt_d = '0;
                tmo_d     = '0;
            end else begin
                tmo_d = tmo_q + TMO_W'(1);
            end
        end
    end

    // Receiver state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bit_cnt_q    <= '0;
            shift_q      <= '0;
            tmo_q        <= '0;
            byte_q       <= '0;
            byte_valid_q <= 1'b0;
        end else begin
            bit_cnt_q    <= bit_cnt_d;
            shift_q      <= shift_d;
            tmo_q        <= tmo_d;
            byte_q       <= byte_d;
            byte_valid_q <= byte_valid_d;
        end
    end

    assign byte_o       = byte_q;
    assign byte_valid_o = byte_valid_q;

endmodule

// File: rtl/keyboard_ctl.sv
// PS/2 keyboard controller: receives set-2 scancodes and tracks the last
// held mapped key. Optional frame checking via KEYBOARD_PARITY_CHECK_EN.
module keyboard_ctl
    import vga_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 65000
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ps2_clk,
    input  logic             ps2_data,
    output logic [KEY_W-1:0] key,
    output logic             key_valid,
    output logic             frame_err
);

    logic [BYTE_W-1:0] rx_byte;
    logic              rx_valid;
    logic              rx_err;
    key_t              rx_key_c;

    dec_state_t        state_q, state_d;
    key_t              key_q,   key_d;
    logic              key_valid_q, key_valid_d;

    ps2_rx #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_rx (
        .clk          (clk),
        .rst_n        (rst_n),
        .ps2_clk_i    (ps2_clk),
        .ps2_data_i   (ps2_data),
        .byte_o       (rx_byte),
        .byte_valid_o (rx_valid),
        .frame_err_o  (rx_err)
    );

    assign rx_key_c = sc_to_key(rx_byte);

    // Decoder state and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= DEC_IDLE;
            key_q       <= key_relesed;
            key_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            key_q       <= key_d;
            key_valid_q <= key_valid_d;
        end
    end

    // Prefix tracking; moves only when a byte arrives.
    always_comb begin
        state_d = state_q;
        if (rx_valid) begin
            case (state_q)
                DEC_IDLE: begin
                    if (rx_byte == SC_BREAK) begin
                        state_d = DEC_BREAK;
                    end else if (rx_byte == SC_EXT) begin
                        state_d = DEC_EXT;
                    end else begin
                        state_d = DEC_IDLE;
                    end
                end
                DEC_EXT: begin
                    state_d = (rx_byte == SC_BREAK) ? DEC_EXT_BREAK : DEC_IDLE;
                end
                DEC_BREAK:     state_d = DEC_IDLE;
                DEC_EXT_BREAK: state_d = DEC_IDLE;
                default:       state_d = DEC_IDLE;
            endcase
        end
    end

    // Key update: makes overwrite, a break only releases the key it names.
    always_comb begin
        key_d = key_q;
        if (rx_valid) begin
            case (state_q)
                DEC_IDLE: begin
                    if (rx_key_c != key_relesed) begin
                        key_d = rx_key_c;
                    end
                end
                DEC_BREAK: begin
                    if ((key_q != key_relesed) && (rx_key_c == key_q)) begin
                        key_d = key_relesed;
                    end
                end
                default: key_d = key_q;
            endcase
        end
        key_valid_d = (key_d != key_q);
    end

    assign key       = key_q;
    assign key_valid = key_valid_q;
    assign frame_err = rx_err;

endmodule

// File: tb/tb_keyboard_ctl.sv
// Bench for keyboard_ctl: randomized PS/2 traffic against a scancode-level model.
module tb_keyboard_ctl;

    localparam int unsigned TO = 1000;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       ps2_clk;
    logic       ps2_data;
    logic [3:0] key;
    logic       key_valid;
    logic       frame_err;

    keyboard_ctl #(.TIMEOUT_CYCLES(TO)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .ps2_clk   (ps2_clk),
        .ps2_data  (ps2_data),
        .key       (key),
        .key_valid (key_valid),
        .frame_err (frame_err)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int last_drv = 0;
    logic cmp_en = 1'b0;

    // model state
    int         m_nbits;
    int         m_last;
    logic [10:0] m_frame;
    logic       m_brk, m_ext;
    logic [3:0] m_cur;
    logic [3:0] exp_key;
    int         sk_cyc, se_cyc;
    logic [3:0] sk_val;
    logic       exp_v, exp_e;
    int         vld_cnt = 0, err_cnt = 0;

    logic [7:0] sc_tab [10] = '{8'h00, 8'h1C, 8'h1B, 8'h1D, 8'h23, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h76};

    function automatic logic [3:0] ref_map(input logic [7:0] b);
        logic [3:0] k;
        k = 4'd0;
        for (int i = 1; i < 10; i++) if (sc_tab[i] == b) k = 4'(i);
        return k;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h cycle=%0d", name, act, req, cyc);
        end
    endtask

    task automatic model_reset();
        m_nbits = 0; m_last = 0; m_frame = '0;
        m_brk = 1'b0; m_ext = 1'b0; m_cur = 4'd0;
        exp_key = 4'd0; sk_cyc = -1; se_cyc = -1; sk_val = 4'd0;
    endtask

    task automatic model_byte(input logic [7:0] b);
        logic [3:0] k, nk;
        k  = ref_map(b);
        nk = m_cur;
        if (m_ext) begin
            if (!m_brk && b == 8'hF0) m_brk = 1'b1;
            else begin m_ext = 1'b0; m_brk = 1'b0; end
        end else if (m_brk) begin
            if (k != 4'd0 && k == m_cur) nk = 4'd0;
            m_brk = 1'b0;
        end else if (b == 8'hF0) m_brk = 1'b1;
        else if (b == 8'hE0) m_ext = 1'b1;
        else if (k != 4'd0) nk = k;
        m_cur  = nk;
        sk_cyc = cyc + 4;
        sk_val = nk;
    endtask

    task automatic model_frame();
        logic ok;
        ok = (m_frame[0] == 1'b0) && ((^m_frame[9:1]) == 1'b1) && (m_frame[10] == 1'b1);
`ifdef KEYBOARD_PARITY_CHECK_EN
        if (!ok) se_cyc = cyc + 3;
        else     model_byte(m_frame[8:1]);
`else
        if (ok || !ok) model_byte(m_frame[8:1]);
`endif
    endtask

    task automatic model_fall(input logic d);
        if (m_nbits != 0 && (cyc - m_last) > int'(TO)) m_nbits = 0;
        m_last = cyc;
        m_frame[m_nbits] = d;
        m_nbits++;
        if (m_nbits == 11) begin
            m_nbits = 0;
            model_frame();
        end
    endtask

    // Per-cycle comparison of all outputs against the model.
    always @(posedge clk) begin
        cyc = cyc + 1;
        #1;
        if (cmp_en && rst_n === 1'b1) begin
            exp_v = 1'b0;
            exp_e = 1'b0;
            if (cyc == sk_cyc) begin
                exp_v   = (sk_val != exp_key);
                exp_key = sk_val;
            end
            if (cyc == se_cyc) exp_e = 1'b1;
            check("cycle{key,valid,err}", 32'({key, key_valid, frame_err}), 32'({exp_key, exp_v, exp_e}));
            if (key_valid === 1'b1) vld_cnt++;
            if (frame_err === 1'b1) err_cnt++;
        end
    end

    task automatic ps2_bit(input logic d, input int gap);
        ps2_data = d;
        @(negedge clk);
        while (cyc - last_drv < gap) @(negedge clk);
        ps2_clk  = 1'b0;
        last_drv = cyc;
        model_fall(d);
        repeat (2) @(negedge clk);
        ps2_clk = 1'b1;
    endtask

    function automatic logic [10:0] mkframe(input logic [7:0] b, input int corrupt);
        logic [10:0] f;
        f = {1'b1, ~(^b), b, 1'b0};
        if (corrupt == 1) f[9]  = ~f[9];
        if (corrupt == 2) f[0]  = 1'b1;
        if (corrupt == 3) f[10] = 1'b0;
        return f;
    endfunction

    task automatic send_bits(input logic [10:0] f, input int lo, input int hi, input int first_gap);
        for (int i = lo; i <= hi; i++)
            ps2_bit(f[i], (i == lo && first_gap > 0) ? first_gap : int'($urandom_range(4, 12)));
    endtask

    task automatic settle();
        repeat ($urandom_range(8, 20)) @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b, input int corrupt);
        send_bits(mkframe(b, corrupt), 0, 10, 0);
        settle();
    endtask

    task automatic release_held();
        if (m_cur != 4'd0) begin
            send_byte(8'hF0, 0);
            send_byte(sc_tab[m_cur], 0);
        end
    endtask

    int v0, e0;
    logic [10:0] fr;

    initial begin
        rst_n = 1'b0; ps2_clk = 1'b1; ps2_data = 1'b1;
        model_reset();
        repeat (3) @(negedge clk);
        check("reset_key", 32'(key), 32'h0);
        check("reset_key_valid", 32'(key_valid), 32'h0);
        check("reset_frame_err", 32'(frame_err), 32'h0);
        rst_n = 1'b1; cmp_en = 1'b1; last_drv = cyc;
        repeat (5) @(negedge clk);

        // make then break
        v0 = vld_cnt;
        send_byte(8'h1C, 0);
        check("make_A_key", 32'(key), 32'h1);
        check("make_A_pulses", 32'(vld_cnt - v0), 32'd1);
        v0 = vld_cnt;
        send_byte(8'hF0, 0); send_byte(8'h1C, 0);
        check("break_A_key", 32'(key), 32'h0);
        check("break_A_pulses", 32'(vld_cnt - v0), 32'd1);

        // typematic repeat
        v0 = vld_cnt;
        send_byte(8'h1C, 0); send_byte(8'h1C, 0); send_byte(8'h1C, 0);
        check("repeat_key", 32'(key), 32'h1);
        check("repeat_pulses", 32'(vld_cnt - v0), 32'd1);
        release_held();

        // last pressed wins; stale break ignored
        send_byte(8'h1D, 0); send_byte(8'h23, 0);
        check("overwrite_key", 32'(key), 32'h4);
        v0 = vld_cnt;
        send_byte(8'hF0, 0); send_byte(8'h1D, 0);
        check("stale_break_key", 32'(key), 32'h4);
        check("stale_break_pulses", 32'(vld_cnt - v0), 32'd0);
        release_held();

        // extended codes never touch key
        v0 = vld_cnt;
        send_byte(8'hE0, 0); send_byte(8'h1C, 0);
        send_byte(8'hE0, 0); send_byte(8'hF0, 0); send_byte(8'h1C, 0);
        check("ext_key", 32'(key), 32'h0);
        check("ext_pulses", 32'(vld_cnt - v0), 32'd0);

        // bad parity
        v0 = vld_cnt; e0 = err_cnt;
        send_byte(8'h1C, 1);
`ifdef KEYBOARD_PARITY_CHECK_EN
        check("bad_parity_key", 32'(key), 32'h0);
        check("bad_parity_err", 32'(err_cnt - e0), 32'd1);
`else
        check("bad_parity_key", 32'(key), 32'h1);
        check("bad_parity_err", 32'(err_cnt - e0), 32'd0);
`endif
        release_held();

        // idle gap of exactly TO cycles inside a frame is tolerated
        v0 = vld_cnt;
        fr = mkframe(8'h1B, 0);
        send_bits(fr, 0, 4, 0);
        send_bits(fr, 5, 5, int'(TO));
        send_bits(fr, 6, 10, 0);
        settle();
        check("gap_at_limit_key", 32'(key), 32'h2);
        check("gap_at_limit_pulses", 32'(vld_cnt - v0), 32'd1);

        // partial frame abandoned after TO+1 cycle gap, then full frame
        e0 = err_cnt;
        fr = mkframe(8'h1C, 0);
        send_bits(fr, 0, 4, 0);
        send_bits(mkframe(8'h76, 0), 0, 10, int'(TO) + 1);
        settle();
        check("timeout_key", 32'(key), 32'h9);
        check("timeout_err", 32'(err_cnt - e0), 32'd0);

        // reset mid-frame
        fr = mkframe(8'h1D, 0);
        send_bits(fr, 0, 4, 0);
        rst_n = 1'b0;
        model_reset();
        #1;
        check("midreset_key", 32'(key), 32'h0);
        check("midreset_valid", 32'(key_valid), 32'h0);
        repeat (4) @(negedge clk);
        rst_n = 1'b1;
        last_drv = cyc;
        repeat (3) @(negedge clk);
        send_byte(8'h1C, 0);
        check("after_reset_key", 32'(key), 32'h1);

        // randomized traffic
        for (int n = 0; n < 150; n++) begin
            logic [7:0] b;
            int r, c;
            r = int'($urandom_range(0, 9));
            if (r <= 5)      b = sc_tab[$urandom_range(1, 9)];
            else if (r == 6) b = (m_cur != 4'd0) ? sc_tab[m_cur] : 8'hF0;
            else if (r == 7) b = 8'hE0;
            else if (r == 8) b = 8'hF0;
            else             b = 8'($urandom);
            c = ($urandom_range(0, 7) == 0) ? int'($urandom_range(1, 3)) : 0;
            send_byte(b, c);
        end

        repeat (10) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/keyboard_ctl.md
KEYBOARD_CTL -- requirements
Module: keyboard_ctl

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 65000, is the idle window in clk cycles (1 ms at 65 MHz) after which a partial PS/2 frame is abandoned.
REQ-002 clk  input  1  system clock (65 MHz pixel clock domain).
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 ps2_clk  input  1  raw PS/2 clock from the keyboard, asynchronous to clk.
REQ-005 ps2_data  input  1  raw PS/2 data from the keyboard, asynchronous to clk.
REQ-006 key  output  4  currently held key code (key_relesed, key_A..key_esc encoding from the shared package).
REQ-007 key_valid  output  1  one-cycle pulse when key changes value.
REQ-008 frame_err  output  1  one-cycle pulse on a rejected PS/2 frame.

Function
REQ-009 ps2_clk and ps2_data SHALL each pass through a 2-flop synchronizer; a bit is sampled on each synchronized ps2_clk falling edge.
REQ-010 Frame SHALL be 11 bits: start 0, 8 data bits LSB first, odd parity, stop 1.
REQ-011 Receiver SHALL assert an internal byte-valid strobe for 1 cycle, 1 cycle after the 11th falling edge is detected.
REQ-012 A frame with start=1, bad parity or stop=0 SHALL be discarded, with frame_err pulsed for 1 cycle in place of the byte strobe.
REQ-013 Bit counter nonzero with no falling edge for TIMEOUT_CYCLES consecutive cycles SHALL reset the bit counter to 0, discard the partial frame silently, and not pulse frame_err.
REQ-014 Decoder FSM states: IDLE, BREAK, EXT, EXT_BREAK; it advances only on a byte strobe.
REQ-015 IDLE: 8'hF0 -> BREAK; 8'hE0 -> EXT; mapped make code -> key set to its code, stay IDLE; other codes ignored.
REQ-016 BREAK: byte equal to the scancode of the held key -> key = key_relesed; any other byte ignored; always -> IDLE.
REQ-017 EXT: 8'hF0 -> EXT_BREAK; other -> IDLE, byte discarded. EXT_BREAK: any byte -> IDLE, discarded (extended keys never affect key).
REQ-018 Mapping (set 2): 1C->key_A, 1B->key_S, 1D->key_W, 23->key_D, 16->key_1, 1E->key_2, 26->key_3, 25->key_4, 76->key_esc.
REQ-019 A mapped make while a different key is held SHALL overwrite key (last-pressed wins).
REQ-020 key and key_valid SHALL update 1 cycle after the byte strobe; key_valid pulses only if the new key differs from the old key (typematic repeats produce no pulse).
REQ-021 Byte strobe and timeout in the same cycle: byte wins (timeout counter cleared).

Reset
REQ-022 rst_n low SHALL immediately set key=key_relesed, key_valid=0, frame_err=0, FSM=IDLE, bit counter=0, timeout counter=0, synchronizer flops=1.
REQ-023 Reset asserted mid-frame SHALL discard the partial frame; after release, reception restarts at the next start bit.

Configuration
REQ-024 With KEYBOARD_PARITY_CHECK_EN defined, REQ-012 checks apply.
REQ-025 Without KEYBOARD_PARITY_CHECK_EN, every 11-bit frame SHALL be accepted regardless of start/parity/stop, and frame_err SHALL be tied to 0.

Structure
REQ-026 Scancode constants (SC_BREAK=8'hF0, SC_EXT=8'hE0, SC_A..SC_ESC) and the decoder state enum typedef SHALL live in vga_pkg beside the existing key codes.
REQ-027 Frame reception (REQ-009..013) SHALL be a sub-module ps2_rx producing byte/strobe/err; keyboard_ctl instantiates it and holds the decoder FSM.

Verification
REQ-028 Send 1C -> key=0001, key_valid 1 pulse; then F0,1C -> key=0000, key_valid 1 pulse.
REQ-029 Send 1C,1C,1C -> key=0001, exactly one key_valid pulse.
REQ-030 Send 1D then 23, then F0,1D -> key=0100 after 23; F0,1D leaves key=0100, no pulse.
REQ-031 Send E0,1C then E0,F0,1C -> key stays 0000, no key_valid.
REQ-032 Send 1C with parity flipped -> frame_err 1 pulse, key unchanged (with macro); key=0001 (without macro).
REQ-033 Send 5 bits, idle 65000 cycles, then full 76 -> key=1001, no frame_err; rst_n low mid-frame -> key=0000 immediately.
